pipelined_cla_adder: RTL and testbench
======================================

Name: pipelined_cla_adder

Overview:
Parametrised, pipelined carry-lookahead adder/subtractor built from 4-bit CLA groups, with one group evaluated per pipeline stage.
- Operands enter through a valid/ready handshake.
- Result and flags leave WIDTH/GROUP cycles later through a second valid/ready handshake.
- Throughput: one operation per cycle.
- Serves as the wide arithmetic datapath element behind the lab's ALU and accumulator blocks.

Parameters:
WIDTH, 16, operand/result width in bits; must be a multiple of GROUP, range 4..64
GROUP, 4, bits per CLA group; fixed at 4 in this generation, elaborate-time check rejects other values
STAGES, WIDTH/GROUP, derived pipeline depth; not overridable

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  operand set present
in_ready  out  1  block can accept an operand set this cycle
a  in  WIDTH  operand A
b  in  WIDTH  operand B
cin  in  1  carry-in; ignored when sub=1
sub  in  1  0: a+b+cin; 1: a-b (computed as a+~b+1)
out_valid  out  1  result present
out_ready  in  1  consumer accepts result
sum  out  WIDTH  result
cout  out  1  carry out of MSB; for sub, 1 = no borrow
ovf  out  1  two's-complement signed overflow
zero  out  1  sum == 0

Behaviour:
- Reset (async assert, sync release): all valid bits, carries, skew/deskew registers, sum, cout, ovf and zero clear to 0. Any in-flight operations are discarded with no partial output. in_ready is 1 one cycle after release.
- Handshake:
  - Accept when in_valid && in_ready.
  - Deliver when out_valid && out_ready.
  - in_ready = !out_valid || out_ready. This combinational path from out_ready is permitted.
  - The whole pipeline advances when in_ready=1 and freezes when in_ready=0 (global stall).
  - All stage registers, including valid bits, hold their values while stalled.
  - Outputs stay stable while out_valid && !out_ready.
- Operand prep at accept: b_eff = sub ? ~b : b; c0 = sub ? 1 : cin.
- Stage k (k = 0..STAGES-1):
  - Computes group k bits [4k+3:4k] from the skewed a/b_eff and the registered carry from stage k-1 (c0 for k=0).
  - Computes the group using 4-bit CLA equations: p = a^b, g = a&b, full lookahead to c4.
  - Registers the 4 sum bits and the carry out.
  - Higher operand groups travel through skew registers; lower result groups travel through deskew registers.
- Latency: exactly STAGES cycles from accept to out_valid when not stalled (WIDTH=16 gives 4 cycles). Stalls add cycles 1:1.
- Flags, valid together with sum:
  - cout = carry out of the last group.
  - ovf = carry into MSB XOR carry out of MSB; the carry into the MSB is registered alongside the last group.
  - zero = ~|sum.
- Back-to-back issue: a new operation may be accepted every cycle. Independent operations never interact; each stage carries its own carry and valid bit.
- Boundaries:
  - in_valid=0 inserts a bubble (valid=0) that flows through the pipeline.
  - Simultaneous accept and deliver with a full pipeline is legal and loses nothing.
  - Wrap-around is modulo 2^WIDTH; cout reports the wrap.

Optional Feature:
Macro CLA_SATURATE_EN.
- Defined: when ovf=1, sum is replaced by the signed limit, 2^(WIDTH-1)-1 if the MSB of a is 0, else -2^(WIDTH-1). ovf still reads 1, zero is computed on the saturated value, cout is unchanged, and latency is unchanged because the mux sits in the final stage.
- Undefined: sum is the plain modulo result and no saturation logic exists.

Decomposition:
- Shared package cla_pkg holds: localparam GROUP_W=4; function sat_max/sat_min(width); a typedef for the per-stage record {valid, carry, partial sum}.
- One natural sub-module: cla_group4, a purely combinational 4-bit lookahead group with ports a, b, ci, s, co, and msb_ci for overflow detection. It is instantiated STAGES times; the parent holds all registers.

Test Plan:
1. WIDTH=16, a=0xFFFF, b=0x0001, cin=0, sub=0 -> 4 cycles later: sum=0x0000, cout=1, ovf=0, zero=1.
2. a=0x7FFF, b=0x0001, sub=0 -> sum=0x8000, ovf=1, cout=0. With CLA_SATURATE_EN: sum=0x7FFF, ovf=1.
3. a=0x0005, b=0x0007, sub=1, cin=1 (ignored) -> sum=0xFFFE, cout=0, ovf=0, zero=0. Then a=0x0007, b=0x0005 -> sum=0x0002, cout=1.
4. Issue 8 random operations back-to-back, out_ready held 0 from cycle 3 to cycle 9 -> in_ready drops when out_valid rises. All 8 results arrive in order and match the reference model, with no drops or duplicates and the held output stable.
5. Fill the pipeline with 4 operations, assert rst_n=0 for 1 cycle mid-flight -> out_valid=0 immediately; no stale result ever appears. The first operation issued after release is correct after 4 cycles.
6. WIDTH=32 elaboration, a=0x0000FFFF, b=0xFFFF0001 -> 8-cycle latency, sum=0x00000000, cout=1, zero=1. WIDTH=18 must fail elaboration.

Source files
------------

// File: rtl/cla_pkg.sv
// -----------------------------------------------------------------------------
// cla_pkg
// Shared definitions for the pipelined carry-lookahead adder:
//   GROUP_W   bits handled by one lookahead group (and one pipeline stage)
//   MAX_W     widest supported operand width
//   stage_t   per-stage pipeline record {valid, carry, partial sum of group}
//   sat_max / sat_min   signed saturation limits for a given width
// -----------------------------------------------------------------------------
package cla_pkg;

    localparam int GROUP_W = 4;
    localparam int MAX_W   = 64;

    // The group sum produced by a stage rides with its carry and valid bit;
    // the next stage folds it into the deskewed result vector.
    typedef struct packed {
        logic               valid;
        logic               carry;
        logic [GROUP_W-1:0] psum;
    } stage_t;

    // Largest positive two's-complement value of the given width.
    function automatic logic [MAX_W-1:0] sat_max(input int width);
        return (MAX_W'(1) << (width - 1)) - MAX_W'(1);
    endfunction

    // Most negative two's-complement value of the given width.
    function automatic logic [MAX_W-1:0] sat_min(input int width);
        return MAX_W'(1) << (width - 1);
    endfunction

endpackage

// File: rtl/pipelined_cla_adder_group4.sv
// -----------------------------------------------------------------------------
// cla_group4
// Purely combinational 4-bit carry-lookahead group.
// Ports:
//   a, b    4-bit operands (b already inverted for subtraction)
//   ci      carry into bit 0
//   s       4-bit sum
//   co      carry out of bit 3
//   msb_ci  carry into bit 3, used for signed overflow in the top group
// -----------------------------------------------------------------------------
module cla_group4
    import cla_pkg::*;
(
    input  logic [GROUP_W-1:0] a,
    input  logic [GROUP_W-1:0] b,
    input  logic               ci,
    output logic [GROUP_W-1:0] s,
    output logic               co,
    output logic               msb_ci
);

    logic [GROUP_W-1:0] p;
    logic [GROUP_W-1:0] g;
    logic               c1, c2, c3, c4;

    assign p = a ^ b;
    assign g = a & b;

    // Every carry is a flat sum-of-products of generate/propagate terms, so no
    // carry depends on another carry inside the group.
    assign c1 = g[0] | (p[0] & ci);
    assign c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    assign c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & ci);
    assign c4 = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & ci);

    assign s      = p ^ {c3, c2, c1, ci};
    assign co     = c4;
    assign msb_ci = c3;

endmodule

// File: rtl/pipelined_cla_adder.sv
// -----------------------------------------------------------------------------
// pipelined_cla_adder
// Pipelined carry-lookahead adder/subtractor. One 4-bit lookahead group is
// evaluated per stage, so the result appears WIDTH/4 cycles after accept, with
// one new operation accepted per cycle. Higher operand groups travel down
// skew registers; finished low result groups travel down deskew registers.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   operand handshake (a, b, cin, sub)
//   sub                   0: a+b+cin   1: a-b (cin ignored)
//   out_valid / out_ready result handshake (sum, cout, ovf, zero)
//   cout                  carry out of MSB (for subtract, 1 = no borrow)
//   ovf                   two's-complement overflow
//   zero                  sum == 0
//
// Build option: define CLA_SATURATE_EN to clamp sum to the signed limit when
// ovf is set (the clamp sits in the last stage, latency unchanged).
// -----------------------------------------------------------------------------
module pipelined_cla_adder
    import cla_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int GROUP = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int STAGES = WIDTH / GROUP_W;
    // Intermediate stage registers; the last stage feeds the output registers.
    localparam int PIPE_N = (STAGES > 1) ? STAGES - 1 : 1;

    if (GROUP != GROUP_W || (WIDTH % GROUP) != 0 || WIDTH < 4 || WIDTH > MAX_W) begin : g_bad_cfg
        $error("pipelined_cla_adder: WIDTH must be a multiple of 4 in 4..64 and GROUP must be 4");
    end

`ifdef CLA_SATURATE_EN
    localparam logic [WIDTH-1:0] SAT_MAX = WIDTH'(sat_max(WIDTH));
    localparam logic [WIDTH-1:0] SAT_MIN = WIDTH'(sat_min(WIDTH));
`endif

    // Intermediate pipeline state (stage k output, k = 0..STAGES-2).
    stage_t           st_q  [PIPE_N];
    logic [WIDTH-1:0] a_q   [PIPE_N];  // skew: operand A
    logic [WIDTH-1:0] b_q   [PIPE_N];  // skew: effective operand B
    logic [WIDTH-1:0] acc_q [PIPE_N];  // deskew: groups 0..k-1 of the result

    // Output registers, written by the last stage.
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;

    logic advance;

    // Global stall: every register advances together or holds together.
    assign in_ready = !out_valid_q || out_ready;
    assign advance  = in_ready;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic             s_valid;
        logic             s_carry;
        logic [WIDTH-1:0] s_a;
        logic [WIDTH-1:0] s_b;
        logic [WIDTH-1:0] s_acc;
        logic [GROUP_W-1:0] grp_s;
        logic             grp_co;
        logic             grp_mci;

        if (k == 0) begin : g_in
            // Operand prep: subtraction is a + ~b + 1.
            always_comb begin
                s_valid = in_valid;
                s_carry = sub ? 1'b1 : cin;
                s_a     = a;
                s_b     = sub ? ~b : b;
                s_acc   = '0;
            end
        end else begin : g_in
            always_comb begin
                s_valid = st_q[k-1].valid;
                s_carry = st_q[k-1].carry;
                s_a     = a_q[k-1];
                s_b     = b_q[k-1];
                s_acc   = acc_q[k-1] | (WIDTH'(st_q[k-1].psum) << (GROUP_W * (k - 1)));
            end
        end

        cla_group4 u_group (
            .a      (s_a[GROUP_W*k +: GROUP_W]),
            .b      (s_b[GROUP_W*k +: GROUP_W]),
            .ci     (s_carry),
            .s      (grp_s),
            .co     (grp_co),
            .msb_ci (grp_mci)
        );

        if (k < STAGES - 1) begin : g_mid
            stage_t           st_d;
            logic [WIDTH-1:0] a_d, b_d, acc_d;

            always_comb begin
                st_d.valid = s_valid;
                st_d.carry = grp_co;
                st_d.psum  = grp_s;
                a_d        = s_a;
                b_d        = s_b;
                acc_d      = s_acc;
            end

            // NOTE: every pipeline register is reset, so a reset mid-flight
            // discards all operations and nothing stale can reach the output.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    st_q[k]  <= '0;
                    a_q[k]   <= '0;
                    b_q[k]   <= '0;
                    acc_q[k] <= '0;
                end else if (advance) begin
                    st_q[k]  <= st_d;
                    a_q[k]   <= a_d;
                    b_q[k]   <= b_d;
                    acc_q[k] <= acc_d;
                end
            end
        end else begin : g_last
            logic [WIDTH-1:0] full_sum;

            // NOTE: every variable is assigned on every path through this
            // block, so no latch is inferred.
            always_comb begin
                full_sum    = s_acc | (WIDTH'(grp_s) << (GROUP_W * k));
                out_valid_d = s_valid;
                cout_d      = grp_co;
                // Signed overflow: carry into MSB differs from carry out.
                ovf_d       = grp_mci ^ grp_co;
`ifdef CLA_SATURATE_EN
                // The sign of a picks the limit: a positive operand can only
                // overflow upward, a negative one only downward.
                sum_d       = ovf_d ? (s_a[WIDTH-1] ? SAT_MIN : SAT_MAX) : full_sum;
`else
                sum_d       = full_sum;
`endif
                zero_d      = ~|sum_d;
            end
        end
    end

    // NOTE: non-blocking assignments here so every flop samples pre-edge
    // values regardless of block evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            zero_q      <= 1'b0;
        end else if (advance) begin
            out_valid_q <= out_valid_d;
            sum_q       <= sum_d;
            cout_q      <= cout_d;
            ovf_q       <= ovf_d;
            zero_q      <= zero_d;
        end
    end

    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// -----------------------------------------------------------------------------
// tb_pipelined_cla_adder
// Directed bench for pipelined_cla_adder: a 16-bit instance for the main
// checks and a 32-bit instance for the wide-latency case. Expected values are
// hand-computed; when CLA_SATURATE_EN is defined the overflowing cases expect
// the clamped sum instead.
// -----------------------------------------------------------------------------
module tb_pipelined_cla_adder;

    localparam int W   = 16;
    localparam int W32 = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // 16-bit instance signals
    logic         in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf, zero;
    logic [W-1:0] a, b, sum;

    // 32-bit instance signals
    logic           in_valid32, in_ready32, out_valid32, out_ready32, cout32, ovf32, zero32;
    logic [W32-1:0] a32, b32, sum32;

    pipelined_cla_adder #(.WIDTH(W), .GROUP(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf),
        .zero      (zero)
    );

    pipelined_cla_adder #(.WIDTH(W32), .GROUP(4)) dut32 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid32),
        .in_ready  (in_ready32),
        .a         (a32),
        .b         (b32),
        .cin       (1'b0),
        .sub       (1'b0),
        .out_valid (out_valid32),
        .out_ready (out_ready32),
        .sum       (sum32),
        .cout      (cout32),
        .ovf       (ovf32),
        .zero      (zero32)
    );

    typedef struct packed {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
        logic         zero;
    } exp_t;

    typedef struct packed {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic         sub;
        logic [W-1:0] s;
        logic         c;
        logic         v;
    } vec_t;

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t exp_q[$];
    vec_t vecs[8];
    logic mon_en = 1'b0;
    logic held = 1'b0;
    logic [W-1:0] held_sum;
    int   delivered = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Builds the expected record from hand-computed modulo sum and flags.
    function automatic exp_t mk_exp(input logic [W-1:0] a_in, input logic [W-1:0] s,
                                    input logic c, input logic v);
        exp_t e;
        e.sum  = s;
        e.cout = c;
        e.ovf  = v;
`ifdef CLA_SATURATE_EN
        if (v) e.sum = a_in[W-1] ? 16'h8000 : 16'h7FFF;
`endif
        e.zero = (e.sum == '0);
        return e;
    endfunction

    // One isolated operation with out_ready held high; checks latency and result.
    task automatic single_op(input string tag, input logic [W-1:0] ai, input logic [W-1:0] bi,
                             input logic ci, input logic si, input exp_t e);
        int lat;
        @(posedge clk); #1;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        a = ai; b = bi; cin = ci; sub = si;
        check({tag, ".in_ready"}, 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, ".latency"}, 64'(lat), 64'd4);
        check({tag, ".sum"},  64'(sum),  64'(e.sum));
        check({tag, ".cout"}, 64'(cout), 64'(e.cout));
        check({tag, ".ovf"},  64'(ovf),  64'(e.ovf));
        check({tag, ".zero"}, 64'(zero), 64'(e.zero));
    endtask

    // Stream monitor: in-order delivery, hold stability and stall behaviour.
    always @(negedge clk) begin : mon
        exp_t e;
        if (mon_en) begin
            if (held) begin
                check("stream.hold_valid", 64'(out_valid), 64'd1);
                check("stream.hold_sum",   64'(sum),       64'(held_sum));
            end
            if (out_valid && !out_ready)
                check("stream.in_ready_low", 64'(in_ready), 64'd0);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("stream.unexpected_output", 64'(exp_q.size()), 64'd1);
                end else begin
                    e = exp_q.pop_front();
                    check("stream.sum",  64'(sum),  64'(e.sum));
                    check("stream.cout", 64'(cout), 64'(e.cout));
                    check("stream.ovf",  64'(ovf),  64'(e.ovf));
                    check("stream.zero", 64'(zero), 64'(e.zero));
                    delivered++;
                end
            end
            held     = out_valid && !out_ready;
            held_sum = sum;
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int stale;
        int budget;
        logic ok;

        in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        in_valid32 = 1'b0; out_ready32 = 1'b1; a32 = '0; b32 = '0;

        vecs[0] = '{16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0};
        vecs[1] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[2] = '{16'h00FF, 16'h0F01, 1'b1, 1'b0, 16'h1001, 1'b0, 1'b0};
        vecs[3] = '{16'h1000, 16'h0001, 1'b0, 1'b1, 16'h0FFF, 1'b1, 1'b0};
        vecs[4] = '{16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1};
        vecs[5] = '{16'hABCD, 16'h5433, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[6] = '{16'h0003, 16'h0003, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
        vecs[7] = '{16'h4000, 16'h4000, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("reset.out_valid", 64'(out_valid), 64'd0);
        check("reset.sum",       64'(sum),       64'd0);
        check("reset.cout",      64'(cout),      64'd0);
        check("reset.ovf",       64'(ovf),       64'd0);
        check("reset.zero",      64'(zero),      64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("reset.in_ready_after_release", 64'(in_ready), 64'd1);

        // Wrap to zero, signed overflow, subtraction with ignored cin
        single_op("t1_wrap",  16'hFFFF, 16'h0001, 1'b0, 1'b0, mk_exp(16'hFFFF, 16'h0000, 1'b1, 1'b0));
        single_op("t2_ovf",   16'h7FFF, 16'h0001, 1'b0, 1'b0, mk_exp(16'h7FFF, 16'h8000, 1'b0, 1'b1));
        single_op("t3_sub_neg", 16'h0005, 16'h0007, 1'b1, 1'b1, mk_exp(16'h0005, 16'hFFFE, 1'b0, 1'b0));
        single_op("t3_sub_pos", 16'h0007, 16'h0005, 1'b1, 1'b1, mk_exp(16'h0007, 16'h0002, 1'b1, 1'b0));

        // Back-to-back stream with a consumer stall
        @(posedge clk); #1;
        exp_q.delete();
        delivered = 0;
        held = 1'b0;
        mon_en = 1'b1;
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    in_valid = 1'b1;
                    a = vecs[i].a; b = vecs[i].b; cin = vecs[i].cin; sub = vecs[i].sub;
                    budget = 0;
                    do begin
                        @(negedge clk);
                        ok = in_ready;
                        if (ok) exp_q.push_back(mk_exp(vecs[i].a, vecs[i].s, vecs[i].c, vecs[i].v));
                        @(posedge clk); #1;
                        budget++;
                    end while (!ok && budget < 50);
                    if (!ok) check("stream.accept_timeout", 64'(ok), 64'd1);
                end
                in_valid = 1'b0;
                a = '0; b = '0; cin = 1'b0; sub = 1'b0;
            end
            begin
                out_ready = 1'b1;
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (7) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        budget = 0;
        while (exp_q.size() > 0 && budget < 100) begin
            @(posedge clk); #1;
            budget++;
        end
        @(posedge clk); #1;
        mon_en = 1'b0;
        check("stream.drained",   64'(exp_q.size()), 64'd0);
        check("stream.delivered", 64'(delivered),    64'd8);

        // Reset with a full pipeline
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            a = 16'h1111 * 16'(i + 1); b = 16'h0101; cin = 1'b0; sub = 1'b0;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        check("rst_mid.full_before", 64'(out_valid), 64'd1);
        rst_n = 1'b0;
        #1;
        check("rst_mid.out_valid_now", 64'(out_valid), 64'd0);
        check("rst_mid.sum_now",       64'(sum),       64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        stale = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (out_valid) stale++;
        end
        check("rst_mid.stale_outputs", 64'(stale), 64'd0);
        single_op("rst_mid.first_op", 16'h0123, 16'h0456, 1'b1, 1'b0, mk_exp(16'h0123, 16'h057A, 1'b0, 1'b0));

        // 32-bit instance: eight-stage latency
        @(posedge clk); #1;
        in_valid32 = 1'b1;
        a32 = 32'h0000FFFF; b32 = 32'hFFFF0001;
        @(posedge clk); #1;
        in_valid32 = 1'b0;
        a32 = '0; b32 = '0;
        lat = 1;
        while (!out_valid32 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check("w32.latency", 64'(lat),    64'd8);
        check("w32.sum",     64'(sum32),  64'd0);
        check("w32.cout",    64'(cout32), 64'd1);
        check("w32.ovf",     64'(ovf32),  64'd0);
        check("w32.zero",    64'(zero32), 64'd1);

        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
